ppu_pix_mux: RTL

Parametrised pixel compositor and palette unit for the PPU.
- Takes per-pixel palette indices from one background layer and LAYERS-1 sprite channels.
- Resolves priority and transparency, looks the result up in the internal palette RAM, and applies an optional monochrome mode.
- Emits the 6-bit system palette index to ppu_vga through a 2-stage pipeline.
- Provides the CPU-side palette RAM port and the latched primary-object collision flag.

---
 rtl/ppu_pix_pkg.sv | 22 ++
 rtl/ppu_pram.sv | 51 +++++
 rtl/ppu_pix_mux.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ppu_pix_pkg.sv
// rtl/ppu_pix_pkg.sv - shared constants and helpers for the PPU pixel compositor
package ppu_pix_pkg;

    localparam int IDX_W_DEF = 4;
    localparam int PAL_W_DEF = 6;
    localparam int PRAM_AW   = IDX_W_DEF + 1;
    // Widest palette RAM address the helper functions handle (IDX_W up to 7)
    localparam int MIR_W     = 8;

    localparam logic [5:0] MONO_MASK = 6'h30;

    // Every palette RAM address whose low two bits are zero aliases entry 0
    function automatic logic [MIR_W-1:0] pram_mirror(input logic [MIR_W-1:0] addr);
        return (addr[1:0] == 2'b00) ? '0 : addr;
    endfunction

    // A layer index is opaque when its colour-within-palette bits are non-zero
    function automatic logic is_opaque(input logic [1:0] idx_lo);
        return idx_lo != 2'b00;
    endfunction

endpackage

// File: rtl/ppu_pram.sv
// rtl/ppu_pram.sv - palette RAM with CPU port (write-first) and render read port (read-old)
module ppu_pram
    import ppu_pix_pkg::*;
#(
    parameter int AW = PRAM_AW,
    parameter int DW = PAL_W_DEF
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [AW-1:0] cpu_a_i,
    input  logic [DW-1:0] cpu_d_i,
    input  logic          cpu_wr_i,
    output logic [DW-1:0] cpu_d_o,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_a_i,
    output logic [DW-1:0] rd_d_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [AW-1:0] cpu_a_m;
    logic [AW-1:0] rd_a_m;
    logic [DW-1:0] cpu_d_q;
    logic [DW-1:0] rd_d_q;

    assign cpu_a_m = AW'(pram_mirror(MIR_W'(cpu_a_i)));
    assign rd_a_m  = AW'(pram_mirror(MIR_W'(rd_a_i)));

    // CPU write into the mirrored entry; contents are not reset
    always_ff @(posedge clk_i) begin
        if (cpu_wr_i) begin
            mem_q[cpu_a_m] <= cpu_d_i;
        end
    end

    // Read registers: CPU port forwards write data, render port sees pre-write contents
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cpu_d_q <= '0;
            rd_d_q  <= '0;
        end else begin
            cpu_d_q <= cpu_wr_i ? cpu_d_i : mem_q[cpu_a_m];
            if (rd_en_i) begin
                rd_d_q <= mem_q[rd_a_m];
            end
        end
    end

    assign cpu_d_o = cpu_d_q;
    assign rd_d_o  = rd_d_q;

endmodule

// File: rtl/ppu_pix_mux.sv
// rtl/ppu_pix_mux.sv - layer priority/transparency compositor with palette lookup and collision flag
module ppu_pix_mux
    import ppu_pix_pkg::*;
#(
    parameter int LAYERS = 2,
    parameter int IDX_W  = 4,
    parameter int PAL_W  = 6
) (
    input  logic                    clk_in,
    input  logic                    nrst_in,
    input  logic                    pix_pulse_in,
    input  logic [9:0]              nes_y_next_in,
    input  logic [LAYERS*IDX_W-1:0] layer_idx_in,
    input  logic [LAYERS-1:0]       layer_bhnd_in,
    input  logic [LAYERS-1:0]       layer_pri_in,
    input  logic                    mono_in,
    input  logic [IDX_W:0]          pram_a_in,
    input  logic [PAL_W-1:0]        pram_d_in,
    input  logic                    pram_wr_in,
    output logic [PAL_W-1:0]        pram_d_out,
    output logic [PAL_W-1:0]        sys_palette_idx_out,
    output logic                    pix_valid_out
    ,
    output logic                    pri_col_out
);

    localparam int AW = IDX_W + 1;

    logic [IDX_W-1:0] bg_idx;
    logic             bg_op;
    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic             win_bhnd;
    logic             col_hit;
    logic [AW-1:0]    addr_d;

    logic             s1_valid_q;
    logic [AW-1:0]    s1_addr_q;
    logic             s2_valid_q;
    logic             mono_q;
    logic             col_q;
    logic [PAL_W-1:0] rd_data;

    // Background's bhnd/pri bits have no meaning
    logic unused_bg_flags;
    assign unused_bg_flags = layer_bhnd_in[0] ^ layer_pri_in[0];

    assign bg_idx = layer_idx_in[IDX_W-1:0];
    assign bg_op  = is_opaque(bg_idx[1:0]);

    // Pick the lowest-numbered opaque sprite and detect primary-object overlap with background
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_bhnd  = 1'b0;
        col_hit   = 1'b0;
        for (int k = LAYERS - 1; k >= 1; k--) begin
            if (is_opaque(layer_idx_in[k*IDX_W +: 2])) begin
                win_found = 1'b1;
                win_idx   = layer_idx_in[k*IDX_W +: IDX_W];
                win_bhnd  = layer_bhnd_in[k];
                if (layer_pri_in[k] && bg_op) begin
                    col_hit = 1'b1;
                end
            end
        end
        if (win_found && (!win_bhnd || !bg_op)) begin
            addr_d = {1'b1, win_idx};
        end else if (bg_op) begin
            addr_d = {1'b0, bg_idx};
        end else begin
            addr_d = '0;
        end
    end

    // Stage 1 latches the palette address; stage 2 tracks the RAM read and mono mode
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s2_valid_q <= 1'b0;
            mono_q     <= 1'b0;
        end else begin
            s1_valid_q <= pix_pulse_in;
            if (pix_pulse_in) begin
                s1_addr_q <= addr_d;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                mono_q <= mono_in;
            end
        end
    end

    // Collision flag: new-frame clear beats a same-cycle set
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            col_q <= 1'b0;
        end else if (nes_y_next_in == 10'd0) begin
            col_q <= 1'b0;
        end else if (pix_pulse_in && col_hit) begin
            col_q <= 1'b1;
        end
    end

    ppu_pram #(
        .AW (AW),
        .DW (PAL_W)
    ) u_pram (
        .clk_i    (clk_in),
        .rst_ni   (nrst_in),
        .cpu_a_i  (pram_a_in),
        .cpu_d_i  (pram_d_in),
        .cpu_wr_i (pram_wr_in),
        .cpu_d_o  (pram_d_out),
        .rd_en_i  (s1_valid_q),
        .rd_a_i   (s1_addr_q),
        .rd_d_o   (rd_data)
    );

    assign sys_palette_idx_out = mono_q ? (rd_data & PAL_W'(MONO_MASK)) : rd_data;
    assign pix_valid_out       = s2_valid_q;
    assign pri_col_out         = col_q;

endmodule
